stream_monitor: RTL and testbench

STREAM_MONITOR -- requirements
Module: stream_monitor

---
 rtl/stream_monitor_pkg.sv | 29 ++
 rtl/stream_monitor_if.sv | 12 +
 rtl/stream_monitor_sat_cnt.sv | 38 +++
 rtl/stream_monitor.sv | 151 +++++++++++++++
 tb/tb_stream_monitor.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/stream_monitor_pkg.sv
// Shared types for the passive valid/ready stream monitor: FSM state, cycle
// classification and the per-cycle counter-update bundle.
package stream_monitor_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CYC_IDLE  = 2'd0,
        CYC_STALL = 2'd1,
        CYC_XFER  = 2'd2
    } cycle_e;

    // One bit per statistics counter: set when that counter updates this cycle.
    typedef struct packed {
        logic transfer;
        logic stall;
        logic max_stall;
    } cnt_evt_t;

    function automatic cycle_e classify(input logic valid, input logic ready);
        if (!valid) return CYC_IDLE;
        if (!ready) return CYC_STALL;
        return CYC_XFER;
    endfunction

endpackage

// File: rtl/stream_monitor_if.sv
// Valid/ready stream channel with source, sink and read-only monitor views.
interface stream_monitor_if #(
    parameter int unsigned DataWidth = 32
);
    logic                 valid;
    logic                 ready;
    logic [DataWidth-1:0] data;

    modport master  (output valid, output data, input  ready);
    modport slave   (input  valid, input  data, output ready);
    modport monitor (input  valid, input  data, input  ready);
endinterface

// File: rtl/stream_monitor_sat_cnt.sv
// Saturating up-counter with synchronous clear; also exposes the next value
// so callers can act on it in the same cycle the count changes.
module stream_monitor_sat_cnt #(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                inc_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic [CntWidth-1:0] cnt_next_o
);

    logic [CntWidth-1:0] cnt_d, cnt_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;

endmodule

// File: rtl/stream_monitor.sv
// Passive protocol monitor for a valid/ready stream: counts transfers and stalls
// and raises sticky errors. Payload-stability check: COMMON_CELLS_STREAM_MON_DATA_CHECK_EN.
module stream_monitor
    import stream_monitor_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned CntWidth     = 16,
    parameter int unsigned StallTimeout = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 valid_i,
    input  logic                 ready_i,
    input  logic [DataWidth-1:0] data_i,
    output logic [CntWidth-1:0]  transfer_cnt_o,
    output logic [CntWidth-1:0]  stall_cnt_o,
    output logic [CntWidth-1:0]  max_stall_o,
    output logic                 err_valid_drop_o,
    output logic                 err_data_change_o,
    output logic                 err_timeout_o,
    output logic                 err_o
);

    localparam bit                  TimeoutEn  = (StallTimeout != 0);
    localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(StallTimeout);

    cycle_e              cyc;
    cnt_evt_t            evt;
    state_e              state_d, state_q;
    logic [CntWidth-1:0] max_stall_d, max_stall_q;
    logic [CntWidth-1:0] cur_stall_next;
    logic                err_drop_d, err_drop_q;
    logic                err_to_d, err_to_q;
    logic [CntWidth-1:0] transfer_next_unused, stall_next_unused, cur_stall_unused;

    assign cyc = classify(valid_i, ready_i);

    always_comb begin
        evt.transfer  = !clear_i && (cyc == CYC_XFER);
        evt.stall     = !clear_i && (cyc == CYC_STALL);
        evt.max_stall = !clear_i && (cur_stall_next > max_stall_q);
    end

    stream_monitor_sat_cnt #(.CntWidth(CntWidth)) u_transfer_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .inc_i      (evt.transfer),
        .cnt_o      (transfer_cnt_o),
        .cnt_next_o (transfer_next_unused)
    );

    stream_monitor_sat_cnt #(.CntWidth(CntWidth)) u_stall_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .inc_i      (evt.stall),
        .cnt_o      (stall_cnt_o),
        .cnt_next_o (stall_next_unused)
    );

    // Length of the ongoing stall; any non-stall cycle ends it.
    stream_monitor_sat_cnt #(.CntWidth(CntWidth)) u_cur_stall_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i || (cyc != CYC_STALL)),
        .inc_i      (evt.stall),
        .cnt_o      (cur_stall_unused),
        .cnt_next_o (cur_stall_next)
    );

    always_comb begin
        state_d     = state_q;
        max_stall_d = max_stall_q;
        err_drop_d  = err_drop_q;
        err_to_d    = err_to_q;
        if (clear_i) begin
            state_d     = IDLE;
            max_stall_d = '0;
            err_drop_d  = 1'b0;
            err_to_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE:    if (cyc == CYC_STALL) state_d = PENDING;
                PENDING: begin
                    if (cyc != CYC_STALL) state_d = IDLE;
                    if (cyc == CYC_IDLE) err_drop_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
            if (evt.max_stall) max_stall_d = cur_stall_next;
            if (TimeoutEn && (cur_stall_next >= TimeoutVal)) err_to_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            max_stall_q <= '0;
            err_drop_q  <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            max_stall_q <= max_stall_d;
            err_drop_q  <= err_drop_d;
            err_to_q    <= err_to_d;
        end
    end

`ifdef COMMON_CELLS_STREAM_MON_DATA_CHECK_EN
    logic [DataWidth-1:0] data_d, data_q;
    logic                 err_data_d, err_data_q;

    // Payload is latched when a stall begins and must hold until the handshake.
    always_comb begin
        data_d     = data_q;
        err_data_d = err_data_q;
        if (clear_i) begin
            data_d     = '0;
            err_data_d = 1'b0;
        end else if (state_q == IDLE) begin
            if (cyc == CYC_STALL) data_d = data_i;
        end else if (valid_i && (data_i != data_q)) begin
            err_data_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q     <= '0;
            err_data_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            err_data_q <= err_data_d;
        end
    end

    assign err_data_change_o = err_data_q;
`else
    logic data_unused;
    assign data_unused       = ^data_i;
    assign err_data_change_o = 1'b0;
`endif

    assign max_stall_o      = max_stall_q;
    assign err_valid_drop_o = err_drop_q;
    assign err_timeout_o    = err_to_q;
    assign err_o            = err_drop_q | err_data_change_o | err_to_q;

endmodule

// File: tb/tb_stream_monitor.sv
// Directed bench for stream_monitor: three instances (default, StallTimeout=4,
// CntWidth=4) observe one shared channel driven through stream_monitor_if.
module tb_stream_monitor;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;

    always #5 clk = ~clk;

    stream_monitor_if #(.DataWidth(DW)) mon_if ();

    logic [15:0] m_xfer, m_stall, m_max;
    logic        m_drop, m_data, m_to, m_err;
    logic [15:0] t_xfer, t_stall, t_max;
    logic        t_drop, t_data, t_to, t_err;
    logic [3:0]  s_xfer, s_stall, s_max;
    logic        s_drop, s_data, s_to, s_err;

    stream_monitor #(.DataWidth(DW), .CntWidth(16), .StallTimeout(0)) u_main (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .valid_i(mon_if.valid), .ready_i(mon_if.ready), .data_i(mon_if.data),
        .transfer_cnt_o(m_xfer), .stall_cnt_o(m_stall), .max_stall_o(m_max),
        .err_valid_drop_o(m_drop), .err_data_change_o(m_data),
        .err_timeout_o(m_to), .err_o(m_err)
    );

    stream_monitor #(.DataWidth(DW), .CntWidth(16), .StallTimeout(4)) u_to (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .valid_i(mon_if.valid), .ready_i(mon_if.ready), .data_i(mon_if.data),
        .transfer_cnt_o(t_xfer), .stall_cnt_o(t_stall), .max_stall_o(t_max),
        .err_valid_drop_o(t_drop), .err_data_change_o(t_data),
        .err_timeout_o(t_to), .err_o(t_err)
    );

    stream_monitor #(.DataWidth(DW), .CntWidth(4), .StallTimeout(0)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .valid_i(mon_if.valid), .ready_i(mon_if.ready), .data_i(mon_if.data),
        .transfer_cnt_o(s_xfer), .stall_cnt_o(s_stall), .max_stall_o(s_max),
        .err_valid_drop_o(s_drop), .err_data_change_o(s_data),
        .err_timeout_o(s_to), .err_o(s_err)
    );

`ifdef COMMON_CELLS_STREAM_MON_DATA_CHECK_EN
    localparam logic EXP_DATA_ERR = 1'b1;
`else
    localparam logic EXP_DATA_ERR = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic [DW-1:0] d);
        mon_if.valid = v;
        mon_if.ready = r;
        mon_if.data  = d;
    endtask

    // Advance n active edges; outputs are then sampled 1 time unit later.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        drive(1'b0, 1'b0, '0);
        cycles(1);
        clear = 1'b0;
    endtask

    task automatic check_main_zero(input string tag);
        check({tag, "_xfer"},  32'(m_xfer),  32'd0);
        check({tag, "_stall"}, 32'(m_stall), 32'd0);
        check({tag, "_max"},   32'(m_max),   32'd0);
        check({tag, "_err"},   32'({m_drop, m_data, m_to, m_err}), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        drive(1'b0, 1'b0, '0);
        #12;
        check_main_zero("reset");
        check("reset_sat_xfer", 32'(s_xfer), 32'd0);
        rst_n = 1'b1;
        cycles(1);

        // Five back-to-back transfers.
        drive(1'b1, 1'b1, 8'h11);
        cycles(5);
        check("b2b_xfer",  32'(m_xfer),  32'd5);
        check("b2b_stall", 32'(m_stall), 32'd0);
        check("b2b_err",   32'(m_err),   32'd0);
        do_clear();

        // Three stall cycles then a transfer.
        drive(1'b1, 1'b0, 8'h22);
        cycles(2);
        check("stall_lat2", 32'(m_stall), 32'd2);
        cycles(1);
        drive(1'b1, 1'b1, 8'h22);
        cycles(1);
        drive(1'b0, 1'b0, '0);
        cycles(1);
        check("s3x_stall", 32'(m_stall), 32'd3);
        check("s3x_max",   32'(m_max),   32'd3);
        check("s3x_xfer",  32'(m_xfer),  32'd1);
        check("s3x_err",   32'(m_err),   32'd0);
        check("s3x_to4",   32'(t_to),    32'd0);
        do_clear();

        // Valid withdrawn during a stall.
        drive(1'b1, 1'b0, 8'h33);
        cycles(2);
        check("drop_pre", 32'(m_drop), 32'd0);
        drive(1'b0, 1'b0, '0);
        cycles(1);
        check("drop_set", 32'(m_drop), 32'd1);
        cycles(2);
        check("drop_sticky", 32'(m_drop), 32'd1);
        check("drop_err_o",  32'(m_err),  32'd1);
        // Clear wins over a simultaneous transfer.
        clear = 1'b1;
        drive(1'b1, 1'b1, 8'h33);
        cycles(1);
        clear = 1'b0;
        drive(1'b0, 1'b0, '0);
        check_main_zero("clear");

        // Six-cycle stall against StallTimeout=4.
        drive(1'b1, 1'b0, 8'h44);
        cycles(3);
        check("to_after3", 32'(t_to), 32'd0);
        cycles(1);
        check("to_after4", 32'(t_to),  32'd1);
        check("to_err_o",  32'(t_err), 32'd1);
        cycles(2);
        check("to_stall6",  32'(t_stall), 32'd6);
        check("to_max6",    32'(t_max),   32'd6);
        check("to_disabled", 32'(m_to),   32'd0);
        drive(1'b1, 1'b1, 8'h44);
        cycles(1);
        do_clear();

        // Payload changes while stalled.
        drive(1'b1, 1'b0, 8'hA5);
        cycles(1);
        check("data_hold", 32'(m_data), 32'd0);
        drive(1'b1, 1'b0, 8'h5A);
        cycles(1);
        check("data_change", 32'(m_data), 32'(EXP_DATA_ERR));
        check("data_err_o",  32'(m_err),  32'(EXP_DATA_ERR));
        drive(1'b1, 1'b1, 8'h5A);
        cycles(1);
        do_clear();

        // Twenty transfers saturate the 4-bit counter.
        drive(1'b1, 1'b1, 8'h66);
        cycles(20);
        check("sat_xfer4",  32'(s_xfer), 32'd15);
        check("sat_xfer16", 32'(m_xfer), 32'd20);

        // Asynchronous reset in the middle of a stall.
        drive(1'b1, 1'b0, 8'h77);
        cycles(2);
        check("mid_stall", 32'(m_stall), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check_main_zero("async_rst");
        check("async_rst_sat", 32'(s_xfer), 32'd0);
        #3 rst_n = 1'b1;
        drive(1'b0, 1'b0, '0);
        cycles(1);
        check("post_rst_drop", 32'(m_drop), 32'd0);
        check("post_rst_err",  32'(m_err),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
